// File: rtl/fp_mult_pkg.sv
// Shared constants, state type and exponent helper for the sequential
// mantissa multiplier stage.
package fp_mult_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int BIAS   = 127;
  localparam int PROD_W = 2 * MANT_W;
  localparam int EXPS_W = EXP_W + 2;
  localparam int CNT_W  = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two guard bits hold the full -127..383 range as two's complement.
  function automatic logic [EXPS_W-1:0] exp_sum(input logic [EXP_W-1:0] e1,
                                                input logic [EXP_W-1:0] e2);
    return {2'b00, e1} + {2'b00, e2} - EXPS_W'(BIAS);
  endfunction

endpackage

// File: rtl/fp_shift_add_dp.sv
// Radix-2 shift-add datapath: multiplicand, accumulator and multiplier
// registers plus the single adder. Sequencing comes from the parent FSM.
module fp_shift_add_dp
  import fp_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic [MANT_W-1:0] mcand_i,
  input  logic [MANT_W-1:0] mplier_i,
  output logic [PROD_W-1:0] prod_next_o
);

  logic [MANT_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] acc_q, acc_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [MANT_W:0]   sum;

  // {carry,acc,mplier} shifted right by one after the conditional add; the
  // carry lands in the accumulator MSB so it never needs its own register.
  always_comb begin
    sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_next_o = {sum, mplier_q[MANT_W-1:1]};
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    if (clear) begin
      mcand_d  = '0;
      acc_d    = '0;
      mplier_d = '0;
    end else if (load) begin
      mcand_d  = mcand_i;
      acc_d    = '0;
      mplier_d = mplier_i;
    end else if (step) begin
      acc_d    = prod_next_o[PROD_W-1:MANT_W];
      mplier_d = prod_next_o[MANT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/fp_mant_mult_seq.sv
// Single-precision multiply stage: sign XOR, unbiased exponent sum and a
// 48-bit mantissa product from a sequential shift-add datapath.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one shift-add step per cycle, MANT_W steps
//   DONE  | result held with out_valid=1 until out_ready
module fp_mant_mult_seq
  import fp_mult_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     S1,
  input  logic                     S2,
  input  logic [EXP_W-1:0]         E1,
  input  logic [EXP_W-1:0]         E2,
  input  logic [MANT_W-1:0]        M1,
  input  logic [MANT_W-1:0]        M2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     S_out,
  output logic signed [EXPS_W-1:0] E_sum,
  output logic [PROD_W-1:0]        P
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s_q, s_d;
  logic [EXPS_W-1:0]  e_q, e_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic               dp_load, dp_step, dp_clear;
  logic [PROD_W-1:0]  dp_prod_next;

  fp_shift_add_dp u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (dp_load),
    .step        (dp_step),
    .clear       (dp_clear),
    .mcand_i     (M1),
    .mplier_i    (M2),
    .prod_next_o (dp_prod_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    e_d      = e_q;
    p_d      = p_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    dp_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          s_d     = S1 ^ S2;
          e_d     = exp_sum(E1, E2);
          // A zero operand makes the product trivially zero; skip the run.
          if (M1 == '0 || M2 == '0) begin
            state_d = DONE;
            p_d     = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MANT_W - 1)) begin
          state_d = DONE;
          p_d     = dp_prod_next;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          dp_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      e_q     <= e_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S_out     = s_q;
  assign E_sum     = $signed(e_q);
  assign P         = p_q;

endmodule

// File: tb/tb_fp_mant_mult_seq.sv
// Randomized and directed bench for fp_mant_mult_seq, checked every cycle
// against a transaction-level model of the handshake and arithmetic.
module tb_fp_mant_mult_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid, in_ready;
  logic               S1, S2;
  logic [7:0]         E1, E2;
  logic [23:0]        M1, M2;
  logic               out_valid, out_ready;
  logic               S_out;
  logic signed [9:0]  E_sum;
  logic [47:0]        P;

  fp_mant_mult_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .S1(S1), .S2(S2), .E1(E1), .E2(E2), .M1(M1), .M2(M2),
    .out_valid(out_valid), .out_ready(out_ready),
    .S_out(S_out), .E_sum(E_sum), .P(P)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Model: at most one transaction in flight; result visible from a known
  // cycle until the consumer takes it.
  bit          pend = 1'b0;
  logic [47:0] ep;
  int          ee;
  logic        es;
  int          rise;

  always @(negedge clk) begin
    logic [63:0] prod;
    bit          vis;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      vis = pend && (cyc >= rise);
      check("in_ready", in_ready, !pend);
      check("out_valid", out_valid, vis);
      if (vis) begin
        check("P", P, ep);
        check("E_sum", $signed(E_sum), ee);
        check("S_out", S_out, es);
      end
      if (vis && out_ready) begin
        pend = 1'b0;
      end else if (!pend && in_valid) begin
        prod = {40'b0, M1} * {40'b0, M2};
        pend = 1'b1;
        ep   = prod[47:0];
        ee   = int'(E1) + int'(E2) - 127;
        es   = S1 ^ S2;
        rise = cyc + 1 + ((M1 == 0 || M2 == 0) ? 0 : 24);
      end
    end
  end

  task automatic send(input logic s1, input logic s2, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [23:0] m1,
                      input logic [23:0] m2);
    int n = 0;
    S1 = s1; S2 = s2; E1 = e1; E2 = e2; M1 = m1; M2 = m2;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    M1 = 24'($urandom); M2 = 24'($urandom);
    E1 = 8'($urandom);  E2 = 8'($urandom);
    S1 = 1'($urandom);  S2 = 1'($urandom);
  endtask

  task automatic recv(input int stall, output int lat, output logic [47:0] p,
                      output logic signed [9:0] e, output logic s);
    lat = 0;
    p = '0; e = '0; s = 1'b0;
    while (!out_valid && lat < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      check("recv_timeout", 0, 1);
      return;
    end
    p = P; e = E_sum; s = S_out;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_P"}, P, 0);
    check({tag, "_E_sum"}, $signed(E_sum), 0);
    check({tag, "_S_out"}, S_out, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int                lat, lat2;
    logic [47:0]       p, p2;
    logic signed [9:0] e, e2;
    logic              s, s2;
    logic [23:0]       rm1, rm2;
    bit                zero;

    in_valid = 1'b0; out_ready = 1'b0;
    S1 = 1'b0; S2 = 1'b0; E1 = '0; E2 = '0; M1 = '0; M2 = '0;
    #2;
    do_reset("init");

    send(1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000);
    recv(0, lat, p, e, s);
    check("one_lat", lat, 24);
    check("one_P", p, 48'h400000000000);
    check("one_E", e, 127);
    check("one_S", s, 0);

    send(1'b0, 1'b1, 8'd127, 8'd128, 24'hC00000, 24'hC00000);
    recv(1, lat, p, e, s);
    check("onefive_P", p, 48'h900000000000);
    check("onefive_E", e, 128);
    check("onefive_S", s, 1);

    send(1'b0, 1'b0, 8'd0, 8'd127, 24'h000000, 24'h800000);
    check("bypass_valid_now", out_valid, 1);
    recv(2, lat, p, e, s);
    check("bypass_lat", lat, 0);
    check("bypass_P", p, 0);
    check("bypass_E", e, 0);

    send(1'b1, 1'b0, 8'd254, 8'd254, 24'hFFFFFF, 24'hFFFFFF);
    recv(5, lat, p, e, s);
    check("max_P", p, 48'hFFFFFE000001);
    check("max_E", e, 381);
    check("max_S", s, 1);
    check("max_in_ready_after", in_ready, 1);
    check("max_out_valid_after", out_valid, 0);

    send(1'b0, 1'b0, 8'd130, 8'd120, 24'hABCDEF, 24'h123456);
    repeat (10) begin
      @(posedge clk); #1;
    end
    do_reset("mid_run");

    send(1'b0, 1'b1, 8'd100, 8'd27, 24'hA00000, 24'h800000);
    recv(0, lat, p, e, s);
    check("post_reset_lat", lat, 24);
    check("post_reset_P", p, 48'h500000000000);
    check("post_reset_E", e, 0);
    check("post_reset_S", s, 1);

    send(1'b0, 1'b0, 8'd0, 8'd0, 24'h400000, 24'h400000);
    recv(1, lat, p, e, s);
    check("denorm_P", p, 48'h100000000000);
    check("denorm_E", e, -127);

    send(1'b1, 1'b1, 8'd5, 8'd6, 24'h123456, 24'h000000);
    do_reset("in_done");

    send(1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'hC00000);
    fork
      begin
        repeat (3) begin
          @(posedge clk); #1;
        end
        repeat (8) begin
          in_valid = 1'($urandom_range(0, 1));
          M1 = 24'($urandom); M2 = 24'($urandom);
          E1 = 8'($urandom);  E2 = 8'($urandom);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        send(1'b1, 1'b1, 8'd200, 8'd60, 24'hFFFFFF, 24'h000001);
      end
      begin
        recv(3, lat, p, e, s);
        recv(0, lat2, p2, e2, s2);
      end
    join
    check("ignore_first_P", p, 48'h600000000000);
    check("ignore_first_E", e, 127);
    check("ignore_second_P", p2, 48'h000000FFFFFF);
    check("ignore_second_E", e2, 133);
    check("ignore_second_S", s2, 0);

    for (int i = 0; i < 40; i++) begin
      rm1 = 24'($urandom);
      rm2 = 24'($urandom);
      if ($urandom_range(0, 1) == 1) rm1[23] = 1'b1;
      if ($urandom_range(0, 1) == 1) rm2[23] = 1'b1;
      if ($urandom_range(0, 7) == 0) rm1 = '0;
      if ($urandom_range(0, 7) == 0) rm2 = '0;
      zero = (rm1 == 0) || (rm2 == 0);
      send(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), rm1, rm2);
      recv($urandom_range(0, 3), lat, p, e, s);
      check("rand_lat", lat, zero ? 0 : 24);
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
